alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Issue stage directly upstream of the ALU: holds the 32-entry integer register file and
//  selects ALU operands (rs1, then rs2 or the immediate). Latches operands, opcode and rd
//  into one pipeline register with a valid/ready handshake. Drives ALU in1/in2/opcode
//  from that register. Writeback from later stages enters through the wb_* port.
// PARAMETERS
//  XLEN        32  datapath width, in bits
//  REG_ADDR_W  5   register index width; the file holds 2**REG_ADDR_W entries
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous, active-high reset
//  id_valid    in   1           decoder presents an instruction
//  id_ready    out  1           stage accepts the instruction this cycle
//  id_rs1      in   REG_ADDR_W  source register 1 index
//  id_rs2      in   REG_ADDR_W  source register 2 index
//  id_rd       in   REG_ADDR_W  destination register index, passed through
//  id_imm      in   XLEN        sign-extended immediate
//  id_use_imm  in   1           1: in2 = id_imm; 0: in2 = R[rs2]
//  id_opcode   in   4           ALU opcode, passed through unchanged
//  flush       in   1           kill the instruction held in the register
//  wb_en       in   1           register-file write enable
//  wb_rd       in   REG_ADDR_W  write index
//  wb_data     in   XLEN        write data
//  ex_valid    out  1           pipeline register holds a valid instruction
//  ex_ready    in   1           downstream consumes the instruction this cycle
//  ex_in1      out  XLEN        ALU operand 1
//  ex_in2      out  XLEN        ALU operand 2
//  ex_opcode   out  4           ALU opcode
//  ex_rd       out  REG_ADDR_W  destination index for writeback
// BEHAVIOUR
//  - Reset (async, rst=1): all registers R[*]=0; ex_valid=0; ex_in1/ex_in2/ex_opcode/ex_rd=0.
//    Takes effect immediately, including mid-stall. The held instruction is discarded.
//  - id_ready = !ex_valid || ex_ready, a combinational function of state and ex_ready.
//  - Accept = id_valid && id_ready. On the next edge: ex_in1=rd(rs1);
//    ex_in2 = id_use_imm ? id_imm : rd(rs2); ex_opcode/ex_rd captured; ex_valid=1.
//    Latency is exactly 1 cycle from acceptance to ex_valid.
//  - If ex_valid && ex_ready && !accept, then ex_valid=0 next cycle.
//  - If ex_valid && !ex_ready, all ex_* outputs hold stable (no change while stalled).
//  - Operands are snapshots taken at acceptance. A later writeback never alters a held operand.
//  - flush has priority over accept: on that edge ex_valid=0 and the ex_* data values are
//    don't-care. id_ready is not gated by flush, so the decoder must deassert id_valid itself.
//  - Register file: 2 combinational read ports, 1 synchronous write port on the clk edge.
//    Reads of index 0 return 0. A write with wb_rd==0 is ignored.
//  - Writeback is independent of the handshake and occurs on every edge where wb_en=1,
//    including stall and flush cycles.
//  - rs1==rs2 is legal: both reads return the same value.
//  - No hazard detection is done here. The decoder guarantees ordering.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN:
//   defined: rd(i) returns wb_data when wb_en && wb_rd==i && i!=0 in the same cycle
//     (write-through). Same-cycle writeback and issue see the new value.
//   undefined: rd(i) returns the pre-edge R[i]. The decoder must insert 1 bubble after
//     a writeback to a source register. No bypass muxes are synthesised.
// TESTING
//  1 rst=1 mid-stall, ex_valid=1 -> ex_valid=0 and ex_*=0 immediately; all R read 0 after release
//  2 wb x5=0x0000_00FF; next cycle issue rs1=5, rs2=0, use_imm=0, op=4'd0 ->
//    1 cycle later ex_valid=1, in1=0xFF, in2=0, ex_opcode=4'd0
//  3 wb x0=0xDEAD_BEEF, then issue rs1=0 -> in1=0; issue use_imm=1, imm=0xFFFF_FFFC -> in2=0xFFFF_FFFC
//  4 ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and ex_* stable; ex_ready=1 ->
//    next instruction captured on that edge, ex_valid stays 1 (back-to-back throughput)
//  5 same cycle: wb x7=0x1234 and issue rs1=7 (old R7=0x0) -> in1=0x1234 with REGFILE_BYPASS_EN,
//    in1=0x0 without it
//  6 flush=1 in the same cycle as an accept -> ex_valid=0 next cycle; a writeback in that cycle still lands

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: integer register file, operand select and one
// valid/ready pipeline register. Optional write-through read bypass: REGFILE_BYPASS_EN.
module alu_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_use_imm,
  input  logic [3:0]            id_opcode,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_in1,
  output logic [XLEN-1:0]       ex_in2,
  output logic [3:0]            ex_opcode,
  output logic [REG_ADDR_W-1:0] ex_rd
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned OP_W     = 4;

  logic [XLEN-1:0]       regs_q [NUM_REGS];
  logic [XLEN-1:0]       regs_d [NUM_REGS];

  logic                  ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]       ex_in1_q, ex_in1_d;
  logic [XLEN-1:0]       ex_in2_q, ex_in2_d;
  logic [OP_W-1:0]       ex_opcode_q, ex_opcode_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic                  accept;

  // Register file write port; index 0 is hardwired to zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != '0)) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  // Two combinational read ports.
  always_comb begin
    rs1_val = (id_rs1 == '0) ? '0 : regs_q[id_rs1];
    rs2_val = (id_rs2 == '0) ? '0 : regs_q[id_rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_rd == id_rs1) && (id_rs1 != '0)) begin
      rs1_val = wb_data;
    end
    if (wb_en && (wb_rd == id_rs2) && (id_rs2 != '0)) begin
      rs2_val = wb_data;
    end
`endif
  end

  assign id_ready = !ex_valid_q || ex_ready;
  assign accept   = id_valid && id_ready;

  // Pipeline register next state: flush beats accept, drain when consumed.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_in1_d    = ex_in1_q;
    ex_in2_d    = ex_in2_q;
    ex_opcode_d = ex_opcode_q;
    ex_rd_d     = ex_rd_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d  = 1'b1;
      ex_in1_d    = rs1_val;
      ex_in2_d    = id_use_imm ? id_imm : rs2_val;
      ex_opcode_d = id_opcode;
      ex_rd_d     = id_rd;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      ex_valid_q  <= 1'b0;
      ex_in1_q    <= '0;
      ex_in2_q    <= '0;
      ex_opcode_q <= '0;
      ex_rd_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      ex_valid_q  <= ex_valid_d;
      ex_in1_q    <= ex_in1_d;
      ex_in2_q    <= ex_in2_d;
      ex_opcode_q <= ex_opcode_d;
      ex_rd_q     <= ex_rd_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_in1    = ex_in1_q;
  assign ex_in2    = ex_in2_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_rd     = ex_rd_q;

endmodule
